mb_rx_lane_demapper: RTL

Parametrised receive-side lane-to-flit demapper for the mainband PHY. It collects byte-interleaved data from the active receive lanes over one or more beats and assembles complete flits. It supports full-width, half-width (lower or upper) and quarter-width degraded lane modes, with gap-tolerant valid qualification, mid-flit mode-change recovery and an optional lane-reversal mode. It sits between the mainband RX lane deskew/descrambler and the adapter's flit interface.

---
 rtl/mb_rx_lane_demapper_if.sv | 23 ++
 rtl/mb_rx_lane_demapper.sv | 109 ++++++++++
 2 files changed

// File: rtl/mb_rx_lane_demapper_if.sv
// mb_rx_lane_demapper_if: lane-side beat inputs and flit-side outputs of the RX lane demapper.
interface mb_rx_lane_demapper_if #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_W     = 32,
  parameter int FLIT_BYTES = 64
);
  logic [NUM_LANES*LANE_W-1:0] i_lanes;
  logic                        i_valid;
  logic [2:0]                  i_mode;
  logic                        i_lane_rev;
  logic [FLIT_BYTES*8-1:0]     o_flit;
  logic                        o_flit_valid;
  logic                        o_mode_err;
  logic [7:0]                  o_beat_cnt;
  modport master (
    output i_lanes, i_valid, i_mode, i_lane_rev,
    input  o_flit, o_flit_valid, o_mode_err, o_beat_cnt
  );
  modport slave (
    input  i_lanes, i_valid, i_mode, i_lane_rev,
    output o_flit, o_flit_valid, o_mode_err, o_beat_cnt
  );
endinterface

// File: rtl/mb_rx_lane_demapper.sv
// mb_rx_lane_demapper: assembles byte-interleaved beats from the active RX lane group into flits,
// with full/half/quarter lane modes, optional lane reversal and mid-flit mode-change discard.
module mb_rx_lane_demapper #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_W     = 32,
  parameter int FLIT_BYTES = 64
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  mb_rx_lane_demapper_if.slave  bus
);
  localparam int N   = NUM_LANES;
  localparam int BPL = LANE_W / 8;
  localparam int FW  = FLIT_BYTES * 8;
  localparam int AB3 = N * BPL;
  localparam int AB1 = (N / 2) * BPL;
  localparam int AB4 = (N / 4) * BPL;
  localparam int BT3 = FLIT_BYTES / AB3;
  localparam int BT1 = FLIT_BYTES / AB1;
  localparam int BT4 = FLIT_BYTES / AB4;
  if (N % 4 != 0 || LANE_W % 8 != 0 || FW % (N * LANE_W) != 0 || BT4 > 256) begin : g_bad_params
    $error("mb_rx_lane_demapper: illegal parameter combination");
  end
  logic [2:0]        mode_q, mode_d;
  logic              rev_q, rev_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [FW-1:0]     acc_q, acc_d;
  logic [FW-1:0]     flit_q, flit_d;
  logic              flit_valid_q, flit_valid_d;
  logic              mode_err_q, mode_err_d;
  logic              full, half, quart, hi, act, chg;
  logic [7:0]        cnt_b, last;
  logic [FW-1:0]     acc_w;
  logic [LANE_W-1:0] lg [N];
  // lg[k] is logical lane k of the active group after base offset and optional reversal
  always_comb begin
    full  = bus.i_mode == 3'd3;
    half  = bus.i_mode == 3'd1 || bus.i_mode == 3'd2;
    quart = bus.i_mode == 3'd4;
    hi    = bus.i_mode == 3'd2;
    act   = full || half || quart;
    for (int k = 0; k < N; k++) begin
      lg[k] = '0;
      if (full)
        lg[k] = bus.i_lanes[(bus.i_lane_rev ? N-1-k : k)*LANE_W +: LANE_W];
      else if (half && k < N/2)
        lg[k] = bus.i_lanes[((hi ? N/2 : 0) + (bus.i_lane_rev ? N/2-1-k%(N/2) : k%(N/2)))*LANE_W +: LANE_W];
      else if (quart && k < N/4)
        lg[k] = bus.i_lanes[(bus.i_lane_rev ? N/4-1-k%(N/4) : k%(N/4))*LANE_W +: LANE_W];
    end
  end
  always_comb begin
    chg   = (bus.i_mode != mode_q || bus.i_lane_rev != rev_q) && cnt_q != 8'd0;
    cnt_b = chg ? 8'd0 : cnt_q;
    acc_w = chg ? '0 : acc_q;
    last  = full ? 8'(BT3-1) : half ? 8'(BT1-1) : 8'(BT4-1);
    for (int j = 0; j < FLIT_BYTES; j++) begin
      if (bus.i_valid && full && 8'(j/AB3) == cnt_b)
        acc_w[8*j +: 8] = lg[j%N][8*((j%AB3)/N) +: 8];
      if (bus.i_valid && half && 8'(j/AB1) == cnt_b)
        acc_w[8*j +: 8] = lg[j%(N/2)][8*((j%AB1)/(N/2)) +: 8];
      if (bus.i_valid && quart && 8'(j/AB4) == cnt_b)
        acc_w[8*j +: 8] = lg[j%(N/4)][8*((j%AB4)/(N/4)) +: 8];
    end
    mode_d       = bus.i_mode;
    rev_d        = bus.i_lane_rev;
    mode_err_d   = chg;
    flit_d       = flit_q;
    flit_valid_d = 1'b0;
    cnt_d        = cnt_b;
    acc_d        = acc_w;
    if (!act) begin
      cnt_d = 8'd0;
      acc_d = '0;
    end else if (bus.i_valid) begin
      if (cnt_b == last) begin
        flit_d       = acc_w;
        flit_valid_d = 1'b1;
        cnt_d        = 8'd0;
        acc_d        = '0;
      end else begin
        cnt_d = cnt_b + 8'd1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q       <= '0;
      rev_q        <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      rev_q        <= rev_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      mode_err_q   <= mode_err_d;
    end
  end
  assign bus.o_flit       = flit_q;
  assign bus.o_flit_valid = flit_valid_q;
  assign bus.o_mode_err   = mode_err_q;
  assign bus.o_beat_cnt   = cnt_q;
endmodule
